vectored_interrupt_controller: RTL
==================================

Name: vectored_interrupt_controller

Overview:
Parametrised multi-line successor to the single-line PC-redirect interrupt controller. It sits between the PC-next logic and the PC register of the CPU core. It latches up to NUM_IRQ interrupt requests, picks the highest-priority enabled request, and redirects the PC to a per-line vector. It saves the interrupted PC and cause, and restores that PC when mret is signalled by decode.

Parameters:
XLEN, 32, PC/data width
NUM_IRQ, 8, number of interrupt lines (2..32)
ISR_BASE, 32'd20, base vector address
VECTOR_STRIDE, 4, byte distance between per-line vectors
IDW (localparam), $clog2(NUM_IRQ), cause id width

Ports:
clk  input  1  core clock; all registers update on falling edge
reset  input  1  asynchronous, active-low reset
pc_next  input  XLEN  sequential/branch next PC from core
irq  input  NUM_IRQ  raw interrupt lines, synchronous to clk
irq_mask  input  NUM_IRQ  per-line enable (1 = enabled), from CSR
global_ie  input  1  global interrupt enable, from CSR
mret  input  1  return-from-ISR decoded this cycle
pc_next_final  output  XLEN  PC to load into PC register
epc_out  output  XLEN  saved return PC (to CSR file)
cause_out  output  IDW  id of line being/last serviced
irq_ack  output  1  one-cycle pulse on ISR entry
in_isr  output  1  high while in ISR_ENTER or IN_ISR
pending_out  output  NUM_IRQ  pending register, for CSR readback

Behaviour:
- Reset (reset=0, async): state=IDLE, pending=0, irq_prev=0, epc_out=0, cause_out=0, irq_ack=0, in_isr=0.
- Edge capture: pending[i] sets on the falling clk edge where irq[i]=1 and irq_prev[i]=0. A level held high sets pending only once.
- Eligible set = pending & irq_mask. Selected id = lowest index in the eligible set (index 0 has the highest priority).
- States: IDLE, ISR_ENTER, IN_ISR.
- IDLE: pc_next_final=pc_next.
  - If global_ie=1 and eligible!=0 → ISR_ENTER.
  - On that edge: epc_out<=pc_next, cause_out<=selected id, pending[id] cleared.
- ISR_ENTER: lasts exactly 1 cycle; pc_next_final=vector(cause_out); irq_ack=1; → IN_ISR unconditionally.
- IN_ISR: pc_next_final=pc_next while mret=0.
  - If mret=1: pc_next_final=epc_out (combinational, same cycle) and → IDLE.
- mret in IDLE or ISR_ENTER is ignored; pc passes through or the vector is driven.
- New edges arriving in ISR_ENTER/IN_ISR are latched in pending and serviced after return. There is no nesting.
- A new edge on the line being cleared in the same cycle: set wins, and that line stays pending.
- Back-to-back: a pending eligible request in IDLE after mret re-enters on the next edge. The epc for that entry is the restored PC.
- Latency: irq rises before edge N → pending at N → state ISR_ENTER at N+1 → vector PC is loaded at edge N+2.
- Masking or clearing global_ie after entry does not abort the ISR. Masked pending bits are retained.
- Vector arithmetic: ISR_BASE + cause_out*VECTOR_STRIDE, computed in XLEN bits with unsigned wrap.

Optional Feature:
INTC_VECTORED_EN
- Defined: vector = ISR_BASE + id*VECTOR_STRIDE.
- Undefined: every line vectors to ISR_BASE, and software reads cause_out to dispatch. All other behaviour is identical.

Test Plan:
- Reset with irq=8'hFF, global_ie=1 → no entry, pending=0, pc_next_final=pc_next, all outputs 0.
- irq[3] rising, mask=8'hFF, global_ie=1, pc_next=0x100 → 2 edges later pc_next_final=20+12=32 (vectored) for one cycle, irq_ack=1, epc_out=0x100, cause_out=3. Then assert mret → pc_next_final=0x100, state IDLE.
- irq[5] and irq[2] rising in the same cycle → line 2 serviced first. After mret, line 5 enters the next cycle with epc equal to the restored PC and vector 40.
- irq[1] rising with mask[1]=0 → no entry, pending_out[1]=1. Setting mask[1]=1 → entry with cause 1.
- irq[0] rising while in IN_ISR (cause 4) → no preemption. After mret, the next entry has cause_out=0.
- Assert reset low while in IN_ISR → immediate IDLE, in_isr=0, pending cleared. A subsequent mret has no effect.

Source files
------------

// File: rtl/vectored_interrupt_controller_if.sv
// vectored_interrupt_controller_if: core-side PC/IRQ bundle between the CPU datapath and the interrupt controller.
interface vectored_interrupt_controller_if #(
  parameter int XLEN = 32,
  parameter int NUM_IRQ = 8
);
  localparam int IDW = $clog2(NUM_IRQ);
  logic [XLEN-1:0] pc_next;
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_mask;
  logic global_ie;
  logic mret;
  logic [XLEN-1:0] pc_next_final;
  logic [XLEN-1:0] epc_out;
  logic [IDW-1:0] cause_out;
  logic irq_ack;
  logic in_isr;
  logic [NUM_IRQ-1:0] pending_out;
  modport master (
    output pc_next, irq, irq_mask, global_ie, mret,
    input pc_next_final, epc_out, cause_out, irq_ack, in_isr, pending_out
  );
  modport slave (
    input pc_next, irq, irq_mask, global_ie, mret,
    output pc_next_final, epc_out, cause_out, irq_ack, in_isr, pending_out
  );
endinterface

// File: rtl/vectored_interrupt_controller.sv
// vectored_interrupt_controller: edge-latched prioritised IRQs redirect the PC to a vector and restore it on mret.
// Define INTC_VECTORED_EN for per-line vectors; otherwise every line vectors to ISR_BASE.
module vectored_interrupt_controller #(
  parameter int XLEN = 32,
  parameter int NUM_IRQ = 8,
  parameter logic [XLEN-1:0] ISR_BASE = XLEN'(20),
  parameter int VECTOR_STRIDE = 4
) (
  input logic clk,
  input logic reset,
  vectored_interrupt_controller_if.slave bus
);
  localparam int IDW = $clog2(NUM_IRQ);
`ifdef INTC_VECTORED_EN
  localparam bit VECTORED = 1'b1;
`else
  localparam bit VECTORED = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ISR_ENTER, IN_ISR} state_t;
  state_t state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q, pending_q, pending_d, eligible, clr;
  logic [XLEN-1:0] epc_q, epc_d, vec;
  logic [IDW-1:0] cause_q, cause_d, sel;
  logic irq_ack_q, irq_ack_d, in_isr_q, in_isr_d, enter;
  assign eligible = pending_q & bus.irq_mask;
  assign vec = VECTORED ? ISR_BASE + XLEN'(cause_q) * XLEN'(VECTOR_STRIDE) : ISR_BASE;
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) sel = eligible[i] ? IDW'(i) : sel;
  end
  always_comb begin
    enter = state_q == IDLE && bus.global_ie && |eligible;
    clr = enter ? NUM_IRQ'(1) << sel : '0;
    // a fresh edge on the line being cleared keeps it pending
    pending_d = (pending_q & ~clr) | (bus.irq & ~irq_prev_q);
    state_d = enter ? ISR_ENTER :
              state_q == ISR_ENTER ? IN_ISR :
              (state_q == IN_ISR && bus.mret) ? IDLE : state_q;
    epc_d = enter ? bus.pc_next : epc_q;
    cause_d = enter ? sel : cause_q;
    irq_ack_d = state_d == ISR_ENTER;
    in_isr_d = state_d != IDLE;
  end
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      irq_prev_q <= '0;
      pending_q <= '0;
      epc_q <= '0;
      cause_q <= '0;
      irq_ack_q <= 1'b0;
      in_isr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_prev_q <= bus.irq;
      pending_q <= pending_d;
      epc_q <= epc_d;
      cause_q <= cause_d;
      irq_ack_q <= irq_ack_d;
      in_isr_q <= in_isr_d;
    end
  end
  assign bus.pc_next_final = state_q == ISR_ENTER ? vec :
                             (state_q == IN_ISR && bus.mret) ? epc_q : bus.pc_next;
  assign bus.epc_out = epc_q;
  assign bus.cause_out = cause_q;
  assign bus.irq_ack = irq_ack_q;
  assign bus.in_isr = in_isr_q;
  assign bus.pending_out = pending_q;
endmodule
